pll_reset_seq: RTL

Reset sequencer that sits directly downstream of the board PLL wrapper. It holds the PLL in reset after power-up or after a board reset, then waits for the PLL `locked` signal to be stable. It releases the CNN datapath reset only after lock is qualified, and re-runs the sequence on lock timeout or lock loss. It runs on the 50 MHz board reference clock, which is the PLL `refclk`, so it keeps running while the PLL is in reset.

---
 rtl/pll_reset_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer and its synchronizers.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    localparam int unsigned RETRY_W = 32'd4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

    // Counter width: enough bits for the largest terminal count, plus one spare.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return $clog2(m) + 32'd1;
    endfunction

    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
        return (v == RETRY_MAX) ? RETRY_MAX : v + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with synchronous active-high reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// Holds the PLL in reset, qualifies its lock, then releases the CNN datapath
// reset; re-runs the sequence on lock timeout or lock loss.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 32'd16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 32'd1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 32'd50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               logic_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                              LOCK_TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'd1);

    logic               locked_s;
    pll_state_e         state_r;
    pll_state_e         state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_s;
    logic               pll_rst_r;
    logic               pll_rst_s;
    logic               logic_rst_r;
    logic               logic_rst_s;
    logic               ready_r;
    logic               ready_s;

    sync_2ff #(
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state, counter and retry-count logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        retry_s = retry_r;
        case (state_r)
            PLL_RST: begin
                if (cnt_r == RST_LAST) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins over a retry.
                if (locked_s) begin
                    state_s = STABLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s = PLL_RST;
                    cnt_s   = CNT_ZERO;
                    retry_s = retry_inc(retry_r);
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_s = WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == STABLE_LAST) begin
                    state_s = RUN;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_s = PLL_RST;
                    cnt_s   = CNT_ZERO;
                    retry_s = retry_inc(retry_r);
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = PLL_RST;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output decode of the next state, so registered outputs track the state.
    always_comb begin
        pll_rst_s   = 1'b1;
        logic_rst_s = 1'b1;
        ready_s     = 1'b0;
        case (state_s)
            PLL_RST: begin
                pll_rst_s = 1'b1;
            end
            WAIT_LOCK, STABLE: begin
                pll_rst_s = 1'b0;
            end
            RUN: begin
                pll_rst_s   = 1'b0;
                logic_rst_s = 1'b0;
                ready_s     = 1'b1;
            end
            default: begin
                pll_rst_s = 1'b1;
            end
        endcase
    end

    // State, counter, retry and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PLL_RST;
            cnt_r       <= CNT_ZERO;
            retry_r     <= 4'd0;
            pll_rst_r   <= 1'b1;
            logic_rst_r <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            retry_r     <= retry_s;
            pll_rst_r   <= pll_rst_s;
            logic_rst_r <= logic_rst_s;
            ready_r     <= ready_s;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign logic_rst = logic_rst_r;
    assign ready     = ready_r;
    assign retry_cnt = retry_r;

endmodule
